// File: rtl/fifo_pkg.sv
// Shared widths and default thresholds for the synchronous FIFO family.
package fifo_pkg;

   localparam int DEF_AE_THRESH = 1;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   function automatic int def_af_thresh(input int depth);
      return depth - 1;
   endfunction

endpackage

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle for fifo_sync_flags; the FIFO uses the slave side.
interface fifo_sync_flags_if
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
);
   localparam int CW = cnt_width(DEPTH);

   logic                  clr;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clr, wr_en, din, rd_en,
      input  dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, din, rd_en,
      output dout, dout_valid, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/fifo_sync_mem.sv
// Storage array for fifo_sync_flags: one write port, one registered read port, no reset.
module fifo_sync_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int PW         = 3
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [PW-1:0]         i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [PW-1:0]         i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with count, almost flags, read-valid strobe and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_sync_flags
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int AF_THRESH  = def_af_thresh(DEPTH),
   parameter int AE_THRESH  = DEF_AE_THRESH
) (
   input  logic             clk,
   input  logic             rst_n,
   fifo_sync_flags_if.slave s_if
);

   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_mcount;
   logic                  r_dv, r_ovf, r_udf, r_loaded;
   logic [CW-1:0]         w_count;
   logic                  w_empty, w_full, w_rd_acc, w_wr_acc, w_fetch, w_dv_nxt;
   logic                  w_mem_we, w_mem_re;
   logic [DATA_WIDTH-1:0] w_rd_data;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // r_mcount tracks words in the array; in FWFT the output register holds one more
`ifdef FIFO_FWFT_EN
   assign w_count  = r_mcount + CW'(r_dv);
   assign w_empty  = !r_dv;
   assign w_rd_acc = s_if.rd_en && r_dv;
   assign w_fetch  = (r_mcount != '0) && (!r_dv || w_rd_acc);
   assign w_dv_nxt = w_fetch || (r_dv && !w_rd_acc);
`else
   assign w_count  = r_mcount;
   assign w_empty  = (r_mcount == '0);
   assign w_rd_acc = s_if.rd_en && !w_empty;
   assign w_fetch  = w_rd_acc;
   assign w_dv_nxt = w_rd_acc;
`endif

   assign w_full   = (w_count == DEPTH_C);
   assign w_wr_acc = s_if.wr_en && (!w_full || w_rd_acc);
   assign w_mem_we = w_wr_acc && !s_if.clr;
   assign w_mem_re = w_fetch && !s_if.clr;

   fifo_sync_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PW         (PW)
   ) u_mem (
      .clk       (clk),
      .i_wr_en   (w_mem_we),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (s_if.din),
      .i_rd_en   (w_mem_re),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mcount <= '0;
         r_dv     <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
         r_loaded <= 1'b0;
      end else if (s_if.clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_mcount <= '0;
         r_dv     <= 1'b0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_fetch) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_loaded <= 1'b1;
         end
         case ({w_wr_acc, w_fetch})
            2'b10:   r_mcount <= r_mcount + 1'b1;
            2'b01:   r_mcount <= r_mcount - 1'b1;
            default: r_mcount <= r_mcount;
         endcase
         r_dv <= w_dv_nxt;
         if (s_if.wr_en && !w_wr_acc) r_ovf <= 1'b1;
         if (s_if.rd_en && !w_rd_acc) r_udf <= 1'b1;
      end
   end

   // The array has no reset, so dout reads as zero until the first word is loaded
   assign s_if.dout         = r_loaded ? w_rd_data : '0;
   assign s_if.dout_valid   = r_dv;
   assign s_if.count        = w_count;
   assign s_if.empty        = w_empty;
   assign s_if.full         = w_full;
   assign s_if.almost_full  = (w_count >= AF_C);
   assign s_if.almost_empty = (w_count <= AE_C);
   assign s_if.overflow     = r_ovf;
   assign s_if.underflow    = r_udf;

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags at DEPTH=6, DATA_WIDTH=8.
module tb_fifo_sync_flags;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(6)) bus ();

   fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(6)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (bus)
   );

   typedef struct {
      logic       wr, rd, cl;
      logic [7:0] din;
      logic [2:0] cnt;
      logic       e, f, af, ae, dv;
      logic [7:0] dout;
      logic       ov, un;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en = w;
      bus.rd_en = r;
      bus.clr   = c;
      bus.din   = d;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clr   = 1'b0;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 0);
      chk({tag, "_empty"}, 32'(bus.empty), 1);
      chk({tag, "_ae"},    32'(bus.almost_empty), 1);
      chk({tag, "_full"},  32'(bus.full), 0);
      chk({tag, "_af"},    32'(bus.almost_full), 0);
      chk({tag, "_dout"},  32'(bus.dout), 0);
      chk({tag, "_dv"},    32'(bus.dout_valid), 0);
      chk({tag, "_ovf"},   32'(bus.overflow), 0);
      chk({tag, "_udf"},   32'(bus.underflow), 0);
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clr   = 1'b0;
      bus.din   = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_rst("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_rst("rst_rel");

`ifdef FIFO_FWFT_EN
      step(1, 0, 0, 8'hAA);
      chk("fwft_aa_n1_dv", 32'(bus.dout_valid), 0);
      chk("fwft_aa_n1_cnt", 32'(bus.count), 1);
      step(0, 0, 0, 8'h00);
      chk("fwft_aa_n2_dv", 32'(bus.dout_valid), 1);
      chk("fwft_aa_n2_dout", 32'(bus.dout), 32'h00AA);
      chk("fwft_aa_n2_empty", 32'(bus.empty), 0);
      step(1, 0, 0, 8'hBB);
      step(1, 0, 0, 8'hCC);
      chk("fwft_cnt3", 32'(bus.count), 3);
      chk("fwft_hold_aa", 32'(bus.dout), 32'h00AA);
      step(0, 1, 0, 8'h00);
      chk("fwft_bb_dout", 32'(bus.dout), 32'h00BB);
      chk("fwft_bb_dv", 32'(bus.dout_valid), 1);
      step(0, 1, 0, 8'h00);
      chk("fwft_cc_dout", 32'(bus.dout), 32'h00CC);
      chk("fwft_cc_dv", 32'(bus.dout_valid), 1);
      step(0, 1, 0, 8'h00);
      chk("fwft_end_dv", 32'(bus.dout_valid), 0);
      chk("fwft_end_empty", 32'(bus.empty), 1);
      chk("fwft_end_cnt", 32'(bus.count), 0);
      chk("fwft_end_udf", 32'(bus.underflow), 0);
      // full with pop and write together: head advances, count stays DEPTH
      for (int i = 0; i < 7; i++) step(1, 0, 0, 8'(8'h50 + i));
      chk("fwft_full", 32'(bus.full), 1);
      chk("fwft_full_cnt", 32'(bus.count), 6);
      chk("fwft_ovf", 32'(bus.overflow), 1);
      step(1, 1, 0, 8'h60);
      chk("fwft_wr_rd_cnt", 32'(bus.count), 6);
      chk("fwft_wr_rd_dout", 32'(bus.dout), 32'h0051);
`else
      //          wr rd cl din    cnt e  f  af ae dv dout   ov un
      vq.push_back('{1, 0, 0, 8'h10, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0});
      vq.push_back('{1, 0, 0, 8'h11, 2, 0, 0, 0, 0, 0, 8'h00, 0, 0});
      vq.push_back('{1, 0, 0, 8'h12, 3, 0, 0, 0, 0, 0, 8'h00, 0, 0});
      vq.push_back('{1, 0, 0, 8'h13, 4, 0, 0, 0, 0, 0, 8'h00, 0, 0});
      vq.push_back('{1, 0, 0, 8'h14, 5, 0, 0, 1, 0, 0, 8'h00, 0, 0});
      vq.push_back('{1, 0, 0, 8'h15, 6, 0, 1, 1, 0, 0, 8'h00, 0, 0});
      vq.push_back('{1, 1, 0, 8'h16, 6, 0, 1, 1, 0, 1, 8'h10, 0, 0});
      vq.push_back('{1, 0, 0, 8'h17, 6, 0, 1, 1, 0, 0, 8'h10, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 5, 0, 0, 1, 0, 1, 8'h11, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 8'h12, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 3, 0, 0, 0, 0, 1, 8'h13, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 2, 0, 0, 0, 0, 1, 8'h14, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 1, 0, 0, 0, 1, 1, 8'h15, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h16, 1, 0});
      vq.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h16, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h16, 1, 1});
      vq.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 8'h16, 0, 0});
      vq.push_back('{1, 1, 0, 8'h20, 1, 0, 0, 0, 1, 0, 8'h16, 0, 1});
      vq.push_back('{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 1, 8'h20, 0, 1});
      vq.push_back('{0, 0, 1, 8'h00, 0, 1, 0, 0, 1, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h30, 1, 0, 0, 0, 1, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h31, 2, 0, 0, 0, 0, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h32, 3, 0, 0, 0, 0, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h33, 4, 0, 0, 0, 0, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h34, 5, 0, 0, 1, 0, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h35, 6, 0, 1, 1, 0, 0, 8'h20, 0, 0});
      vq.push_back('{1, 0, 0, 8'h36, 6, 0, 1, 1, 0, 0, 8'h20, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 5, 0, 0, 1, 0, 1, 8'h30, 1, 0});
      vq.push_back('{0, 1, 0, 8'h00, 4, 0, 0, 0, 0, 1, 8'h31, 1, 0});
      vq.push_back('{1, 0, 1, 8'h40, 0, 1, 0, 0, 1, 0, 8'h31, 0, 0});
      vq.push_back('{0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h31, 0, 0});

      foreach (vq[i]) begin
         step(vq[i].wr, vq[i].rd, vq[i].cl, vq[i].din);
         chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vq[i].cnt));
         chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vq[i].e));
         chk($sformatf("v%0d_full", i),  32'(bus.full), 32'(vq[i].f));
         chk($sformatf("v%0d_af", i),    32'(bus.almost_full), 32'(vq[i].af));
         chk($sformatf("v%0d_ae", i),    32'(bus.almost_empty), 32'(vq[i].ae));
         chk($sformatf("v%0d_dv", i),    32'(bus.dout_valid), 32'(vq[i].dv));
         chk($sformatf("v%0d_dout", i),  32'(bus.dout), 32'(vq[i].dout));
         chk($sformatf("v%0d_ovf", i),   32'(bus.overflow), 32'(vq[i].ov));
         chk($sformatf("v%0d_udf", i),   32'(bus.underflow), 32'(vq[i].un));
      end

      // overlapped write/read stream wraps both pointers several times
      for (int k = 0; k <= 20; k++) begin
         step(k < 20, k > 0, 0, 8'(k));
         chk($sformatf("wrap%0d_cnt_le2", k), 32'(bus.count <= 2), 1);
         if (k > 0) begin
            chk($sformatf("wrap%0d_dout", k), 32'(bus.dout), 32'(k - 1));
            chk($sformatf("wrap%0d_dv", k), 32'(bus.dout_valid), 1);
         end
      end
      chk("wrap_empty", 32'(bus.empty), 1);
      chk("wrap_udf", 32'(bus.underflow), 0);
`endif

      step(1, 0, 0, 8'h70);
      step(1, 0, 0, 8'h71);
      step(1, 0, 0, 8'h72);
      chk("refill_cnt", 32'(bus.count) >= 2 ? 1 : 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_rst("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_cnt", 32'(bus.count), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Next-generation single-clock FIFO for datapath buffering between producer/consumer blocks in the same clock domain.
- Generalises the basic synchronous FIFO: any DEPTH >= 2 (not only powers of two).
- Adds an occupancy count, almost-full and almost-empty flags with parameter thresholds, a one-cycle read-data valid strobe, sticky overflow/underflow error flags, a synchronous flush, and optional first-word-fall-through output.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 8, capacity in words; any integer >= 2.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active-high.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop acknowledge in FWFT mode).
- dout  out  DATA_WIDTH  read data, registered.
- dout_valid  out  1  dout holds a newly read word.
- full  out  1  count == DEPTH.
- empty  out  1  no readable word.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  CW = $clog2(DEPTH+1)  words currently held.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset is asynchronous on rst_n low; clock is clk. On reset: count=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not reset.
- Pointers are $clog2(DEPTH) bits and wrap explicitly from DEPTH-1 to 0. Full/empty come from the registered count, never from pointer MSB tricks.
- Read accept: rd_acc = rd_en && !empty.
- Write accept: wr_acc = wr_en && (!full || rd_acc). A write to a full FIFO is accepted when a read is accepted in the same cycle.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Standard mode read latency is 1. On rd_acc at edge N, the head word appears on dout and dout_valid is 1 after edge N. dout_valid is a single-cycle pulse per accepted read. dout holds its value when there is no read.
- Write-then-read: a word written at edge N is readable from edge N+1 (empty deasserts after edge N).
- Empty FIFO with rd_en and wr_en in the same cycle: the read is rejected (underflow set) and the write is accepted.
- Error flags: wr_en && !wr_acc sets overflow; rd_en && !rd_acc sets underflow. Both stay set until clr or reset.
- Flag outputs are derived from the registered count only (glitch-free, no combinational path from wr_en/rd_en).
- clr has priority over wr_en/rd_en in the same cycle. It zeroes the pointers, count, dout_valid, overflow and underflow; dout keeps its value.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through mode.
  - dout continuously presents the head word while dout_valid=1; empty = !dout_valid.
  - rd_en with dout_valid=1 pops the head. The next word, if any, is presented after that edge with no bubble.
  - A word written into an empty FIFO at edge N appears on dout with dout_valid=1 after edge N+1.
  - count includes the word held in the output register; capacity stays DEPTH.
- Undefined: standard mode as described under Behaviour.

Decomposition:
- Shared package fifo_pkg:
  - clog2-based width helper for CW and the pointer width.
  - Default threshold constants.
- Natural sub-module fifo_sync_mem: simple dual-port register array with one write port and one synchronous read port, no reset.
- All flag and count logic stays in fifo_sync_flags.

Test Plan:
1. Reset values: DEPTH=6, DATA_WIDTH=8, hold rst_n low, then release -> count=0, empty=1, almost_empty=1, full=0, dout=0, dout_valid=0.
2. Fill, overflow, drain (DEPTH=6): write 0x10..0x15 -> full=1, count=6, almost_full=1 at count 5. Write 0x16 -> rejected, overflow=1. Read 6 times -> dout 0x10..0x15 in order, each with a one-cycle dout_valid pulse, then empty=1.
3. Wrap-around (DEPTH=6): run 20 interleaved write/read pairs with values 0..19 -> pointers wrap past 5, output order is exactly 0..19, count never exceeds 2.
4. Simultaneous read and write: while full, wr_en=rd_en=1 -> both accepted, count stays 6, overflow stays 0. While empty, both high -> write accepted, underflow=1, count becomes 1.
5. Flush and mid-operation reset: at count=4 with overflow set, pulse clr together with wr_en -> count=0, overflow=0, write ignored. Then refill to 3 words and pulse rst_n low mid-cycle -> count=0 immediately.
6. FWFT (FIFO_FWFT_EN defined): write 0xAA into an empty FIFO -> dout=0xAA with dout_valid=1 two edges later. Hold rd_en with 0xBB and 0xCC queued -> 0xBB and 0xCC presented on consecutive cycles with no bubble.
